// File: rtl/wb_pkg.sv
// Shared constants, control bundle and decode helpers for the MIPS write-back stage.
package wb_pkg;

  localparam logic [4:0]  REG_RA              = 5'd31;
  localparam logic [4:0]  REG_ZERO            = 5'd0;
  localparam int unsigned LINK_OFFSET_DEFAULT = 4;

  typedef enum logic [1:0] {
    WD_LINK,
    WD_HILO,
    WD_MEM,
    WD_ALU
  } wd_src_e;

  typedef enum logic [2:0] {
    HL_NONE,
    HL_MADD,
    HL_MSUB,
    HL_MULT,
    HL_MTHI,
    HL_MTLO,
    HL_ILLEGAL
  } hilo_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic hi_to_reg;
    logic hi_or_lo;
    logic hi_write;
    logic lo_write;
    logic madd;
    logic msub;
    logic dont_move;
    logic move_on_not_zero;
    logic jump_and_link;
  } wb_ctl_t;

  // Accumulate ops take precedence over plain HI/LO writes.
  function automatic hilo_op_e decode_hilo_op(input wb_ctl_t c);
    if (c.madd && c.msub)          return HL_ILLEGAL;
    if (c.madd)                    return HL_MADD;
    if (c.msub)                    return HL_MSUB;
    if (c.hi_write && c.lo_write)  return HL_MULT;
    if (c.hi_write)                return HL_MTHI;
    if (c.lo_write)                return HL_MTLO;
    return HL_NONE;
  endfunction

  function automatic wd_src_e decode_wd_src(input wb_ctl_t c);
    if (c.jump_and_link) return WD_LINK;
    if (c.hi_to_reg)     return WD_HILO;
    if (c.mem_to_reg)    return WD_MEM;
    return WD_ALU;
  endfunction

endpackage

// File: rtl/write_back_unit_hilo.sv
// HI/LO accumulator: 2*WIDTH register with madd/msub/mult/mthi/mtlo update.
// BYPASS=1 exposes the value being written this cycle instead of the registered one.
module hilo_accumulator
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  hilo_op_e           op,
  input  logic [2*WIDTH-1:0] product,
  input  logic [WIDTH-1:0]   alu_result,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;

  always_comb begin
    acc_next = acc;
    if (en) begin
      case (op)
        HL_MADD: acc_next = acc + product;
        HL_MSUB: acc_next = acc - product;
        HL_MULT: acc_next = product;
        HL_MTHI: acc_next = {alu_result, acc[WIDTH-1:0]};
        HL_MTLO: acc_next = {acc[2*WIDTH-1:WIDTH], alu_result};
        default: acc_next = acc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc <= '0;
    else     acc <= acc_next;
  end

  assign hi = BYPASS ? acc_next[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign lo = BYPASS ? acc_next[WIDTH-1:0]       : acc[WIDTH-1:0];

endmodule

// File: rtl/write_back_unit.sv
// MIPS write-back stage: MEM/WB register, register-file write muxing, HI/LO ownership.
// Optional: define WRITE_BACK_HILO_BYPASS_EN to forward same-cycle HI/LO updates to mfhi/mflo.
module write_back_unit
  import wb_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LINK_OFFSET = LINK_OFFSET_DEFAULT
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Stall,
  input  logic               Flush,
  input  logic               RegWriteIn,
  input  logic               MemToRegIn,
  input  logic               HiToRegIn,
  input  logic               HiOrLoIn,
  input  logic               HiWriteIn,
  input  logic               LoWriteIn,
  input  logic               MaddIn,
  input  logic               MsubIn,
  input  logic               DontMoveIn,
  input  logic               MoveOnNotZeroIn,
  input  logic               JumpAndLinkIn,
  input  logic [WIDTH-1:0]   ALUResultIn,
  input  logic [2*WIDTH-1:0] ProductIn,
  input  logic [WIDTH-1:0]   MemReadDataIn,
  input  logic [WIDTH-1:0]   MoveDataIn,
  input  logic [WIDTH-1:0]   LinkPCIn,
  input  logic [4:0]         WriteRegisterIn,
  output logic [4:0]         WriteRegister,
  output logic [WIDTH-1:0]   WriteData,
  output logic               RegWrite,
  output logic [WIDTH-1:0]   HiOut,
  output logic [WIDTH-1:0]   LoOut
);

`ifdef WRITE_BACK_HILO_BYPASS_EN
  localparam bit HILO_BYPASS = 1'b1;
`else
  localparam bit HILO_BYPASS = 1'b0;
`endif

  wb_ctl_t            ctl_in;
  wb_ctl_t            ctl_q;
  logic [WIDTH-1:0]   alu_q;
  logic [WIDTH-1:0]   mem_q;
  logic [WIDTH-1:0]   move_q;
  logic [WIDTH-1:0]   link_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [4:0]         wreg_q;
  logic [WIDTH-1:0]   hi_view;
  logic [WIDTH-1:0]   lo_view;
  logic               move_ok;

  assign ctl_in = '{
    reg_write:        RegWriteIn,
    mem_to_reg:       MemToRegIn,
    hi_to_reg:        HiToRegIn,
    hi_or_lo:         HiOrLoIn,
    hi_write:         HiWriteIn,
    lo_write:         LoWriteIn,
    madd:             MaddIn,
    msub:             MsubIn,
    dont_move:        DontMoveIn,
    move_on_not_zero: MoveOnNotZeroIn,
    jump_and_link:    JumpAndLinkIn
  };

  // A bubble only clears control; data fields are don't-care and simply hold.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ctl_q  <= '0;
      alu_q  <= '0;
      mem_q  <= '0;
      move_q <= '0;
      link_q <= '0;
      prod_q <= '0;
      wreg_q <= '0;
    end else if (Flush) begin
      ctl_q  <= '0;
    end else if (!Stall) begin
      ctl_q  <= ctl_in;
      alu_q  <= ALUResultIn;
      mem_q  <= MemReadDataIn;
      move_q <= MoveDataIn;
      link_q <= LinkPCIn;
      prod_q <= ProductIn;
      wreg_q <= WriteRegisterIn;
    end
  end

  hilo_accumulator #(
    .WIDTH  (WIDTH),
    .BYPASS (HILO_BYPASS)
  ) u_hilo (
    .clk        (Clk),
    .rst        (Rst),
    .en         (!Stall),
    .op         (decode_hilo_op(ctl_q)),
    .product    (prod_q),
    .alu_result (alu_q),
    .hi         (hi_view),
    .lo         (lo_view)
  );

  assign HiOut = hi_view;
  assign LoOut = lo_view;

  assign WriteRegister = ctl_q.jump_and_link ? REG_RA : wreg_q;

  always_comb begin
    move_ok = 1'b1;
    if (ctl_q.dont_move && !ctl_q.jump_and_link)
      move_ok = ctl_q.move_on_not_zero ? (move_q != '0) : (move_q == '0);
  end

  assign RegWrite = ctl_q.reg_write && move_ok && (WriteRegister != REG_ZERO);

  always_comb begin
    WriteData = alu_q;
    case (decode_wd_src(ctl_q))
      WD_LINK: WriteData = link_q + WIDTH'(LINK_OFFSET);
      WD_HILO: WriteData = ctl_q.hi_or_lo ? hi_view : lo_view;
      WD_MEM:  WriteData = mem_q;
      default: WriteData = alu_q;
    endcase
  end

endmodule

// File: tb/tb_write_back_unit.sv
// Directed + randomized bench for write_back_unit against a behavioural reference model.
module tb_write_back_unit;

  logic        Clk, Rst, Stall, Flush;
  logic        RegWriteIn, MemToRegIn, HiToRegIn, HiOrLoIn, HiWriteIn, LoWriteIn;
  logic        MaddIn, MsubIn, DontMoveIn, MoveOnNotZeroIn, JumpAndLinkIn;
  logic [31:0] ALUResultIn, MemReadDataIn, MoveDataIn, LinkPCIn;
  logic [63:0] ProductIn;
  logic [4:0]  WriteRegisterIn;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData, HiOut, LoOut;
  logic        RegWrite;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  write_back_unit #(.WIDTH(32), .LINK_OFFSET(4)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush),
    .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .HiToRegIn(HiToRegIn),
    .HiOrLoIn(HiOrLoIn), .HiWriteIn(HiWriteIn), .LoWriteIn(LoWriteIn),
    .MaddIn(MaddIn), .MsubIn(MsubIn), .DontMoveIn(DontMoveIn),
    .MoveOnNotZeroIn(MoveOnNotZeroIn), .JumpAndLinkIn(JumpAndLinkIn),
    .ALUResultIn(ALUResultIn), .ProductIn(ProductIn), .MemReadDataIn(MemReadDataIn),
    .MoveDataIn(MoveDataIn), .LinkPCIn(LinkPCIn), .WriteRegisterIn(WriteRegisterIn),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .HiOut(HiOut), .LoOut(LoOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: the instruction sitting in WB and the 64-bit {HI,LO} value.
  typedef struct packed {
    logic        rw, m2r, h2r, hol, hw, lw, madd, msub, dm, mnz, jal;
    logic [31:0] alu, mem, mv, link;
    logic [63:0] prod;
    logic [4:0]  wreg;
    logic        bubble;
  } stage_t;

  stage_t      m;
  logic [63:0] acc;

  function automatic logic [63:0] acc_after(input stage_t s, input logic [63:0] a, input logic stall);
    if (stall)              return a;
    if (s.madd && s.msub)   return a;
    if (s.madd)             return a + s.prod;
    if (s.msub)             return a - s.prod;
    if (s.hw && s.lw)       return s.prod;
    if (s.hw)               return {s.alu, a[31:0]};
    if (s.lw)               return {a[63:32], s.alu};
    return a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] view;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_rw, cond;
`ifdef WRITE_BACK_HILO_BYPASS_EN
    view = acc_after(m, acc, Stall);
`else
    view = acc;
`endif
    e_wr = m.jal ? 5'd31 : m.wreg;
    if (m.jal)      e_wd = m.link + 32'd4;
    else if (m.h2r) e_wd = m.hol ? view[63:32] : view[31:0];
    else if (m.m2r) e_wd = m.mem;
    else            e_wd = m.alu;
    cond = !m.dm || m.jal || (m.mnz ? (m.mv != 0) : (m.mv == 0));
    e_rw = m.rw && cond && (e_wr != 0);
    chk("hi_out", 64'(HiOut), 64'(view[63:32]));
    chk("lo_out", 64'(LoOut), 64'(view[31:0]));
    chk("reg_write", 64'(RegWrite), 64'(e_rw));
    if (!m.bubble) begin
      chk("write_reg", 64'(WriteRegister), 64'(e_wr));
      chk("write_data", 64'(WriteData), 64'(e_wd));
    end
  endtask

  task automatic tick();
    stage_t      nm;
    logic [63:0] nacc;
    nacc = acc_after(m, acc, Stall);
    nm   = m;
    if (Flush) begin
      nm = '0;
      nm.bubble = 1'b1;
    end else if (!Stall) begin
      nm = '{rw: RegWriteIn, m2r: MemToRegIn, h2r: HiToRegIn, hol: HiOrLoIn,
             hw: HiWriteIn, lw: LoWriteIn, madd: MaddIn, msub: MsubIn,
             dm: DontMoveIn, mnz: MoveOnNotZeroIn, jal: JumpAndLinkIn,
             alu: ALUResultIn, mem: MemReadDataIn, mv: MoveDataIn, link: LinkPCIn,
             prod: ProductIn, wreg: WriteRegisterIn, bubble: 1'b0};
    end
    @(posedge Clk);
    #1;
    m   = nm;
    acc = nacc;
    check_all();
  endtask

  task automatic clear_in();
    Stall = 0; Flush = 0;
    RegWriteIn = 0; MemToRegIn = 0; HiToRegIn = 0; HiOrLoIn = 0; HiWriteIn = 0;
    LoWriteIn = 0; MaddIn = 0; MsubIn = 0; DontMoveIn = 0; MoveOnNotZeroIn = 0;
    JumpAndLinkIn = 0; ALUResultIn = '0; ProductIn = '0; MemReadDataIn = '0;
    MoveDataIn = '0; LinkPCIn = '0; WriteRegisterIn = '0;
  endtask

  initial begin
    logic [63:0] saved;
    Rst = 1'b1;
    clear_in();
    m = '0;
    acc = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_regwrite", 64'(RegWrite), 64'd0);
    chk("rst_wreg", 64'(WriteRegister), 64'd0);
    chk("rst_wdata", 64'(WriteData), 64'd0);
    chk("rst_hi", 64'(HiOut), 64'd0);
    chk("rst_lo", 64'(LoOut), 64'd0);
    Rst = 1'b0;

    // jal link write
    clear_in(); JumpAndLinkIn = 1; RegWriteIn = 1; LinkPCIn = 32'h40; WriteRegisterIn = 5'd9;
    tick();
    chk("jal_wreg", 64'(WriteRegister), 64'd31);
    chk("jal_wdata", 64'(WriteData), 64'h44);
    chk("jal_rw", 64'(RegWrite), 64'd1);

    // movn / movz with a zero rt
    clear_in(); RegWriteIn = 1; DontMoveIn = 1; MoveOnNotZeroIn = 1; WriteRegisterIn = 5;
    ALUResultIn = 32'h1234;
    tick();
    chk("movn_rw", 64'(RegWrite), 64'd0);
    MoveOnNotZeroIn = 0;
    tick();
    chk("movz_rw", 64'(RegWrite), 64'd1);
    chk("movz_wdata", 64'(WriteData), 64'h1234);

    // mult -> madd -> msub
    clear_in(); HiWriteIn = 1; LoWriteIn = 1; ProductIn = 64'h00000002_00000003;
    tick();
    clear_in(); MaddIn = 1; ProductIn = 64'h00000000_FFFFFFFF;
    tick();
    clear_in(); MsubIn = 1; ProductIn = 64'h00000000_FFFFFFFF;
    tick();
`ifndef WRITE_BACK_HILO_BYPASS_EN
    chk("madd_hi", 64'(HiOut), 64'h3);
    chk("madd_lo", 64'(LoOut), 64'h2);
`endif
    clear_in();
    tick();
`ifndef WRITE_BACK_HILO_BYPASS_EN
    chk("msub_hi", 64'(HiOut), 64'h2);
    chk("msub_lo", 64'(LoOut), 64'h3);
`endif

    // Flush with a live write
    clear_in(); RegWriteIn = 1; WriteRegisterIn = 6; Flush = 1;
    tick();
    chk("flush_rw", 64'(RegWrite), 64'd0);

    // Stall for two cycles holding a madd that also writes a register
    clear_in(); RegWriteIn = 1; WriteRegisterIn = 7; ALUResultIn = 32'hAA; MaddIn = 1; ProductIn = 64'd1;
    tick();
    saved = acc;
    Stall = 1; RegWriteIn = 0; ALUResultIn = 32'h55; WriteRegisterIn = 3;
    tick();
    tick();
    chk("stall_wdata", 64'(WriteData), 64'hAA);
    chk("stall_rw", 64'(RegWrite), 64'd1);
`ifndef WRITE_BACK_HILO_BYPASS_EN
    chk("stall_lo", 64'(LoOut), 64'(saved[31:0]));
`endif
    Stall = 0;
    tick();

    // Stall and Flush together load a bubble
    clear_in(); RegWriteIn = 1; WriteRegisterIn = 8;
    tick();
    Stall = 1; Flush = 1;
    tick();
    chk("stallflush_rw", 64'(RegWrite), 64'd0);

    // r0 write suppressed; madd+msub illegal holds HI/LO
    clear_in(); RegWriteIn = 1; WriteRegisterIn = 0;
    tick();
    chk("r0_rw", 64'(RegWrite), 64'd0);
    saved = acc;
    clear_in(); MaddIn = 1; MsubIn = 1; ProductIn = 64'h12345678_9ABCDEF0;
    tick();
    clear_in();
    tick();
    chk("illegal_hi", 64'(HiOut), 64'(saved[63:32]));
    chk("illegal_lo", 64'(LoOut), 64'(saved[31:0]));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      Stall           = ($urandom_range(0, 5) == 0);
      Flush           = ($urandom_range(0, 7) == 0);
      RegWriteIn      = $urandom_range(0, 1);
      MemToRegIn      = $urandom_range(0, 1);
      HiToRegIn       = $urandom_range(0, 1);
      HiOrLoIn        = $urandom_range(0, 1);
      HiWriteIn       = $urandom_range(0, 1);
      LoWriteIn       = $urandom_range(0, 1);
      MaddIn          = ($urandom_range(0, 3) == 0);
      MsubIn          = ($urandom_range(0, 3) == 0);
      DontMoveIn      = $urandom_range(0, 1);
      MoveOnNotZeroIn = $urandom_range(0, 1);
      JumpAndLinkIn   = ($urandom_range(0, 4) == 0);
      ALUResultIn     = $urandom;
      ProductIn       = {$urandom, $urandom};
      MemReadDataIn   = $urandom;
      MoveDataIn      = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
      LinkPCIn        = ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFC : $urandom;
      WriteRegisterIn = 5'($urandom_range(0, 31));
      tick();
    end

    // Asynchronous reset mid-run drops an in-flight write
    clear_in(); HiWriteIn = 1; ALUResultIn = 32'h5;
    tick();
    clear_in();
    tick();
`ifndef WRITE_BACK_HILO_BYPASS_EN
    chk("pre_rst_hi", 64'(HiOut), 64'h5);
`endif
    RegWriteIn = 1; WriteRegisterIn = 3;
    tick();
    #2;
    Rst = 1'b1;
    #1;
    m = '0;
    acc = '0;
    chk("async_rst_hi", 64'(HiOut), 64'd0);
    chk("async_rst_rw", 64'(RegWrite), 64'd0);
    chk("async_rst_wdata", 64'(WriteData), 64'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    clear_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
